// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg: shared clock/debounce constants and channel state encoding
package switch_debounce_pkg;

    localparam int c_CLK_HZ        = 25_000_000;
    localparam int c_DEBOUNCE_10MS = c_CLK_HZ / 100;

    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } state_e;

endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: raw switch pins in, debounced levels and edge pulses out
interface switch_debounce_if #(
    parameter int NUM_SW = 4
);

    logic [NUM_SW-1:0] i_Switch;
    logic [NUM_SW-1:0] o_Switch;
    logic [NUM_SW-1:0] o_Rise_Pulse;
    logic [NUM_SW-1:0] o_Fall_Pulse;

    modport master (
        output i_Switch,
        input  o_Switch,
        input  o_Rise_Pulse,
        input  o_Fall_Pulse
    );

    modport slave (
        input  i_Switch,
        output o_Switch,
        output o_Rise_Pulse,
        output o_Fall_Pulse
    );

endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: one switch synchroniser, stability counter, level FSM and edge pulses
module debounce_channel
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = c_DEBOUNCE_10MS
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise_Pulse,
    output logic o_Fall_Pulse
);

    localparam int            CW   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

    if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
        $error("DEBOUNCE_LIMIT must be 2 or more");
    end

    logic          sync1_q, sync2_q;
    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          rise_q, rise_d, fall_q, fall_d;
    logic          lvl, flip;

    assign lvl = (state_q == S_HIGH);

    // A sample matching the current level restarts the stability count.
    always_comb begin
        flip    = (sync2_q != lvl) && (count_q == LAST);
        state_d = flip ? (lvl ? S_LOW : S_HIGH) : state_q;
        count_d = ((sync2_q == lvl) || flip) ? '0 : count_q + 1'b1;
        rise_d  = flip && !lvl;
        fall_d  = flip && lvl;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_LOW;
            count_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= i_Switch;
            sync2_q <= sync1_q;
            state_q <= state_d;
            count_q <= count_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_Switch     = lvl;
    assign o_Rise_Pulse = rise_q;
    assign o_Fall_Pulse = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: NUM_SW independent debounce channels behind one interface
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = c_DEBOUNCE_10MS
) (
    input logic              i_Clk,
    input logic              i_Reset,
    switch_debounce_if.slave sw
);

    logic [NUM_SW-1:0] lvl, rise, fall;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_ch (
            .i_Clk       (i_Clk),
            .i_Reset     (i_Reset),
            .i_Switch    (sw.i_Switch[i]),
            .o_Switch    (lvl[i]),
            .o_Rise_Pulse(rise[i]),
            .o_Fall_Pulse(fall[i])
        );
    end

    assign sw.o_Switch     = lvl;
    assign sw.o_Rise_Pulse = rise;
    assign sw.o_Fall_Pulse = fall;

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: table vectors, corner sequences and random pins against a window-based model
module tb_switch_debounce;

    localparam int N = 4;
    localparam int L = 4;

    typedef struct {
        logic [N-1:0] pin;
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    switch_debounce_if #(.NUM_SW(N)) sw ();

    switch_debounce #(
        .NUM_SW        (N),
        .DEBOUNCE_LIMIT(L)
    ) dut (
        .i_Clk  (clk),
        .i_Reset(rst),
        .sw     (sw)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_lvl, exp_rise, exp_fall;
    logic [N-1:0] pins[$];
    logic [N-1:0] samp[$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        pins.delete();
        samp.delete();
        exp_lvl  = '0;
        exp_rise = '0;
        exp_fall = '0;
    endtask

    // A level is accepted once the last L synchronised samples all disagree with it.
    task automatic model_edge(input logic [N-1:0] pin);
        logic [N-1:0] s, v;
        bit all;
        int n;
        pins.push_back(pin);
        n = pins.size();
        s = (n >= 3) ? pins[n-3] : '0;
        samp.push_back(s);
        if (pins.size() > 8) pins.delete(0);
        if (samp.size() > 2 * L) samp.delete(0);
        exp_rise = '0;
        exp_fall = '0;
        for (int c = 0; c < N; c++) begin
            if (samp.size() >= L) begin
                all = 1;
                for (int k = 1; k <= L; k++) begin
                    v = samp[samp.size()-k];
                    if (v[c] == exp_lvl[c]) all = 0;
                end
                if (all) begin
                    exp_lvl[c] = ~exp_lvl[c];
                    if (exp_lvl[c]) exp_rise[c] = 1'b1;
                    else exp_fall[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] pin, input string tag);
        sw.i_Switch = pin;
        @(posedge clk);
        model_edge(pin);
        @(negedge clk);
        check({tag, "_lvl"}, sw.o_Switch, exp_lvl);
        check({tag, "_rise"}, sw.o_Rise_Pulse, exp_rise);
        check({tag, "_fall"}, sw.o_Fall_Pulse, exp_fall);
    endtask

    // Called at a falling edge: reset mid-cycle, check the immediate clear, release at next falling edge.
    task automatic reset_mid(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_lvl"}, sw.o_Switch, '0);
        check({tag, "_rst_rise"}, sw.o_Rise_Pulse, '0);
        check({tag, "_rst_fall"}, sw.o_Fall_Pulse, '0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[8];
        int at, cnt;
        logic [N-1:0] rp, p;
        bit seen;
        logic [6:0] bounce;

        sw.i_Switch = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_lvl", sw.o_Switch, '0);

        // Reset and idle
        reset_mid("idle");
        for (int e = 0; e < 20; e++) step(4'b0000, "idle");

        // Clean press on channel 0, fixed expectations
        reset_mid("press");
        for (int k = 0; k < 8; k++) begin
            tv[k].pin  = 4'b0001;
            tv[k].lvl  = (k >= 5) ? 4'b0001 : 4'b0000;
            tv[k].rise = (k == 5) ? 4'b0001 : 4'b0000;
            tv[k].fall = 4'b0000;
        end
        for (int k = 0; k < 8; k++) begin
            sw.i_Switch = tv[k].pin;
            @(posedge clk);
            model_edge(tv[k].pin);
            @(negedge clk);
            check("tv_lvl", sw.o_Switch, tv[k].lvl);
            check("tv_rise", sw.o_Rise_Pulse, tv[k].rise);
            check("tv_fall", sw.o_Fall_Pulse, tv[k].fall);
        end

        // Bounce rejection on channel 1
        bounce = 7'b0110111;
        seen = 0;
        for (int k = 0; k < 13; k++) begin
            p = 4'b0001;
            p[1] = (k < 7) ? bounce[k] : 1'b0;
            step(p, "bounce");
            if (sw.o_Rise_Pulse[1] || sw.o_Fall_Pulse[1] || sw.o_Switch[1]) seen = 1;
        end
        check_int("bounce_no_change", int'(seen), 0);

        // Release after press on channel 2
        for (int k = 0; k < 8; k++) step(4'b0101, "ch2_press");
        at = 0;
        cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            step(4'b0001, "ch2_release");
            if (sw.o_Fall_Pulse[2]) begin
                cnt++;
                if (at == 0) at = e;
            end
        end
        check_int("ch2_fall_edge", at, 6);
        check_int("ch2_fall_count", cnt, 1);

        // Simultaneous press on channels 0 and 3
        for (int k = 0; k < 8; k++) step(4'b0000, "idle2");
        at = 0;
        rp = '0;
        for (int e = 1; e <= 10; e++) begin
            step(4'b1001, "simul");
            if (at == 0 && sw.o_Rise_Pulse != '0) begin
                at = e;
                rp = sw.o_Rise_Pulse;
            end
        end
        check_int("simul_edge", at, 6);
        check("simul_rise", rp, 4'b1001);
        check("simul_lvl", sw.o_Switch, 4'b1001);
        reset_mid("async");

        // Reset mid-count with the pin still pressed
        for (int k = 0; k < 3; k++) step(4'b0000, "pre6");
        for (int k = 0; k < 4; k++) step(4'b0001, "midcnt");
        reset_mid("midcnt");
        at = 0;
        cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            step(4'b0001, "after_rst");
            if (sw.o_Rise_Pulse[0]) cnt++;
            if (at == 0 && sw.o_Switch[0]) at = e;
        end
        check_int("rst_rise_edge", at, 6);
        check_int("rst_rise_count", cnt, 1);

        // Random pins with occasional resets
        p = '0;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 4) == 0) p[c] = ~p[c];
            if ($urandom_range(0, 79) == 0) reset_mid("rand");
            step(p, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
